// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master bridge and its timeout counter.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam int unsigned APB_ADDR_W         = 32;
   localparam int unsigned APB_DATA_W         = 32;
   localparam int unsigned APB_TIMEOUT_CYCLES = 255;

   // Bits needed to hold every count from 0 up to and including limit.
   function automatic int unsigned ctr_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response handshake plus APB3 bus signals; master = bridge side, slave = requester/peripheral side.
interface apb_master_bridge_if
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W = APB_ADDR_W,
   parameter int unsigned DATA_W = APB_DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_write;
   logic [DATA_W-1:0] req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   logic [ADDR_W-1:0] Paddr;
   logic              Psel;
   logic              Penable;
   logic              Pwrite;
   logic [DATA_W-1:0] Pwdata;
   logic [DATA_W-1:0] Prdata;
   logic              Pready;
   logic              Pslverr;

   modport master (
      input  req_valid, req_addr, req_write, req_wdata, resp_ready,
      input  Prdata, Pready, Pslverr,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output Paddr, Psel, Penable, Pwrite, Pwdata
   );

   modport slave (
      output req_valid, req_addr, req_write, req_wdata, resp_ready,
      output Prdata, Pready, Pslverr,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  Paddr, Psel, Penable, Pwrite, Pwdata
   );

endinterface

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait-state watchdog; only built when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_ctr
   import apb_pkg::*;
#(
   parameter int unsigned LIMIT = APB_TIMEOUT_CYCLES
) (
   input  logic Pclk,
   input  logic Prst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = ctr_width(LIMIT);

   logic [CW-1:0] count;

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // Fires on the stalled cycle whose increment would bring the count up to LIMIT.
   always_comb begin
      expired = enable && (count == CW'(LIMIT - 1));
   end

endmodule
`endif

// File: rtl/apb_master_bridge.sv
// Single-beat MMIO request to APB3 transfer bridge (SETUP, ACCESS with wait states, RESP).
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = APB_ADDR_W,
   parameter int unsigned DATA_W         = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
   input logic                 Pclk,
   input logic                 Prst,
   apb_master_bridge_if.master bus
);

   apb_state_e        state;
   logic [ADDR_W-1:0] paddr_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              timeout;

`ifdef APB_TIMEOUT_EN
   apb_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .Pclk    (Pclk),
      .Prst    (Prst),
      .clear   (state == SETUP),
      .enable  ((state == ACCESS) && !bus.Pready),
      .expired (timeout)
   );
`else
   // The limit has no effect without the watchdog; ACCESS waits for Pready forever.
   localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
   always_comb begin
      timeout = 1'b0;
   end
`endif

   always_ff @(posedge Pclk or negedge Prst) begin
      if (!Prst) begin
         state    <= IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  paddr_q  <= bus.req_addr;
                  pwrite_q <= bus.req_write;
                  pwdata_q <= bus.req_wdata;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               state <= ACCESS;
            end
            ACCESS: begin
               // A real completion always wins over a watchdog firing in the same cycle.
               if (bus.Pready) begin
                  rdata_q <= pwrite_q ? '0 : bus.Prdata;
                  err_q   <= bus.Pslverr;
                  state   <= RESP;
               end else if (timeout) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= RESP;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes decode straight from state so an asynchronous reset drops them at once.
   always_comb begin
      bus.req_ready  = (state == IDLE);
      bus.Psel       = (state == SETUP) || (state == ACCESS);
      bus.Penable    = (state == ACCESS);
      bus.resp_valid = (state == RESP);
      bus.Paddr      = paddr_q;
      bus.Pwrite     = pwrite_q;
      bus.Pwdata     = pwdata_q;
      bus.resp_rdata = rdata_q;
      bus.resp_err   = err_q;
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench: each transfer's timeline is planned up front into per-cycle drive/expect tables.
module tb_apb_master_bridge;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
`ifdef APB_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 0;
`endif
   localparam int MAXC = 2048;

   logic Pclk = 1'b0;
   logic Prst;
   always #5 Pclk = ~Pclk;

   apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   apb_master_bridge #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .Pclk (Pclk),
      .Prst (Prst),
      .bus  (bus)
   );

   // drive tables
   logic        d_rv     [MAXC];
   logic [31:0] d_addr   [MAXC];
   logic        d_wr     [MAXC];
   logic [31:0] d_wd     [MAXC];
   logic        d_pready [MAXC];
   logic [31:0] d_prdata [MAXC];
   logic        d_pse    [MAXC];
   logic        d_rresp  [MAXC];
   // expectation tables
   logic        e_rr     [MAXC];
   logic        e_psel   [MAXC];
   logic        e_pen    [MAXC];
   logic        e_rv     [MAXC];
   logic        e_pwrite [MAXC];
   logic        e_err    [MAXC];
   logic [31:0] e_paddr  [MAXC];
   logic [31:0] e_pwdata [MAXC];
   logic [31:0] e_rdata  [MAXC];

   int checks    = 0;
   int errors    = 0;
   int idle_from = 0;
   int last_a    = -1;
   int ncyc;

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, c, act, exp);
      end
   endtask

   // Request raised in cycle s; accepted once the bridge is free; w wait states; b cycles of resp backpressure.
   task automatic plan_txn(input int s, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input int w, input logic [31:0] prd, input logic se, input int b);
      int a, r, nacc;
      logic abort;
      logic [31:0] rd;
      logic er;
      a     = (s > idle_from) ? s : idle_from;
      abort = (TO > 0) && (w >= TO);
      nacc  = abort ? TO : w + 1;
      r     = a + 2 + nacc;
      rd    = abort ? 32'h0 : (wr ? 32'h0 : prd);
      er    = abort ? 1'b1 : se;
      for (int c = s; c <= a; c++) begin
         d_rv[c] = 1'b1; d_addr[c] = addr; d_wr[c] = wr; d_wd[c] = wd;
      end
      for (int c = a + 1; c <= r + b; c++) e_rr[c] = 1'b0;
      for (int c = a + 1; c <= a + 1 + nacc; c++) e_psel[c] = 1'b1;
      for (int c = a + 2; c <= a + 1 + nacc; c++) begin
         e_pen[c] = 1'b1; d_pready[c] = 1'b0;
      end
      if (!abort) begin
         d_pready[a + 1 + nacc] = 1'b1;
         d_prdata[a + 1 + nacc] = prd;
         d_pse[a + 1 + nacc]    = se;
      end
      for (int c = r; c <= r + b; c++) begin
         e_rv[c] = 1'b1; d_rresp[c] = (c == r + b);
      end
      for (int c = a + 1; c < MAXC; c++) begin
         e_paddr[c] = addr; e_pwrite[c] = wr; e_pwdata[c] = wd;
      end
      for (int c = r; c < MAXC; c++) begin
         e_rdata[c] = rd; e_err[c] = er;
      end
      last_a    = a;
      idle_from = r + b + 1;
   endtask

   // Hand-derived expectations for the directed opening transfers.
   task automatic pins(input int c);
      case (c)
         3:  begin chk("pin_setup_psel", c, bus.Psel, 1); chk("pin_setup_pen", c, bus.Penable, 0); end
         4:  begin chk("pin_acc_pen", c, bus.Penable, 1); chk("pin_pwdata", c, bus.Pwdata, 32'h12345678); end
         5:  begin chk("pin_wr_rv", c, bus.resp_valid, 1); chk("pin_wr_rdata", c, bus.resp_rdata, 0);
                   chk("pin_wr_err", c, bus.resp_err, 0); end
         10: begin chk("pin_wait_paddr", c, bus.Paddr, 32'h20000004); chk("pin_wait_pen", c, bus.Penable, 1); end
         11: chk("pin_wait_rv_low", c, bus.resp_valid, 0);
         12: begin chk("pin_wait_rv", c, bus.resp_valid, 1); chk("pin_wait_rdata", c, bus.resp_rdata, 32'hDEADBEEF); end
         16: begin chk("pin_slverr_err", c, bus.resp_err, 1); chk("pin_slverr_rdata", c, bus.resp_rdata, 32'hA5A5A5A5); end
         22: begin chk("pin_bp_rv", c, bus.resp_valid, 1); chk("pin_bp_rdata", c, bus.resp_rdata, 32'h0BADF00D);
                   chk("pin_bp_rr", c, bus.req_ready, 0); end
         26: begin chk("pin_b2b_rr", c, bus.req_ready, 1); chk("pin_b2b_psel_low", c, bus.Psel, 0); end
         27: begin chk("pin_b2b_psel", c, bus.Psel, 1); chk("pin_b2b_paddr", c, bus.Paddr, 32'h2000000C); end
`ifdef APB_TIMEOUT_EN
         35: chk("pin_to_pen", c, bus.Penable, 1);
         36: begin chk("pin_to_rv", c, bus.resp_valid, 1); chk("pin_to_err", c, bus.resp_err, 1);
                   chk("pin_to_rdata", c, bus.resp_rdata, 0); chk("pin_to_psel", c, bus.Psel, 0); end
`else
         42: begin chk("pin_long_pen", c, bus.Penable, 1); chk("pin_long_rv_low", c, bus.resp_valid, 0); end
         43: begin chk("pin_long_rv", c, bus.resp_valid, 1); chk("pin_long_rdata", c, bus.resp_rdata, 32'h11111111); end
`endif
         default: ;
      endcase
   endtask

   initial begin
      for (int c = 0; c < MAXC; c++) begin
         d_rv[c] = 1'b0; d_addr[c] = $urandom; d_wr[c] = 1'($urandom_range(0, 1)); d_wd[c] = $urandom;
         d_pready[c] = 1'($urandom_range(0, 1)); d_prdata[c] = $urandom;
         d_pse[c] = 1'($urandom_range(0, 1)); d_rresp[c] = 1'($urandom_range(0, 1));
         e_rr[c] = 1'b1; e_psel[c] = 1'b0; e_pen[c] = 1'b0; e_rv[c] = 1'b0;
         e_pwrite[c] = 1'b0; e_err[c] = 1'b0; e_paddr[c] = '0; e_pwdata[c] = '0; e_rdata[c] = '0;
      end

      plan_txn(2,  32'h20000000, 1'b1, 32'h12345678, 0,  32'h0,        1'b0, 0);
      plan_txn(6,  32'h20000004, 1'b0, 32'h0,        3,  32'hDEADBEEF, 1'b0, 0);
      plan_txn(13, 32'h20000008, 1'b0, 32'h0,        0,  32'hA5A5A5A5, 1'b1, 0);
      plan_txn(17, 32'h20000008, 1'b0, 32'h0,        0,  32'h0BADF00D, 1'b0, 5);
      plan_txn(19, 32'h2000000C, 1'b1, 32'hCAFEF00D, 0,  32'h0,        1'b0, 0);
      plan_txn(30, 32'h20000010, 1'b0, 32'h0,        10, 32'h11111111, 1'b0, 0);
      for (int k = 0; k < 40; k++) begin
         int s, w, b;
         s = last_a + 1 + int'($urandom_range(0, idle_from - last_a + 2));
         w = int'($urandom_range(0, 6));
         b = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 4));
         plan_txn(s, $urandom, 1'($urandom_range(0, 1)), $urandom, w, $urandom,
                  1'($urandom_range(0, 4) == 0), b);
      end
      ncyc = idle_from + 3;

      Prst = 1'b0;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
      bus.resp_ready = 1'b0; bus.Prdata = '0; bus.Pready = 1'b0; bus.Pslverr = 1'b0;
      repeat (3) @(posedge Pclk);
      #1 Prst = 1'b1;

      for (int c = 0; c < ncyc; c++) begin
         bus.req_valid  = d_rv[c];
         bus.req_addr   = d_addr[c];
         bus.req_write  = d_wr[c];
         bus.req_wdata  = d_wd[c];
         bus.Pready     = d_pready[c];
         bus.Prdata     = d_prdata[c];
         bus.Pslverr    = d_pse[c];
         bus.resp_ready = d_rresp[c];
         @(negedge Pclk);
         chk("req_ready",  c, bus.req_ready,  e_rr[c]);
         chk("Psel",       c, bus.Psel,       e_psel[c]);
         chk("Penable",    c, bus.Penable,    e_pen[c]);
         chk("resp_valid", c, bus.resp_valid, e_rv[c]);
         chk("Paddr",      c, bus.Paddr,      e_paddr[c]);
         chk("Pwrite",     c, bus.Pwrite,     e_pwrite[c]);
         chk("Pwdata",     c, bus.Pwdata,     e_pwdata[c]);
         chk("resp_rdata", c, bus.resp_rdata, e_rdata[c]);
         chk("resp_err",   c, bus.resp_err,   e_err[c]);
         pins(c);
         @(posedge Pclk);
         #1;
      end

      // Reset dropped in the middle of an ACCESS phase.
      bus.req_valid = 1'b1; bus.req_addr = 32'h30000010; bus.req_write = 1'b1; bus.req_wdata = 32'h55AA55AA;
      bus.Pready = 1'b0; bus.Pslverr = 1'b0; bus.Prdata = '0; bus.resp_ready = 1'b0;
      @(posedge Pclk); #1 bus.req_valid = 1'b0;
      @(posedge Pclk); #1;
      @(negedge Pclk);
      chk("rst_pre_psel",  ncyc, bus.Psel,    1);
      chk("rst_pre_pen",   ncyc, bus.Penable, 1);
      chk("rst_pre_paddr", ncyc, bus.Paddr,   32'h30000010);
      #1 Prst = 1'b0;
      #1;
      chk("rst_psel",   ncyc, bus.Psel,       0);
      chk("rst_pen",    ncyc, bus.Penable,    0);
      chk("rst_rv",     ncyc, bus.resp_valid, 0);
      chk("rst_rr",     ncyc, bus.req_ready,  1);
      chk("rst_paddr",  ncyc, bus.Paddr,      0);
      chk("rst_pwrite", ncyc, bus.Pwrite,     0);
      chk("rst_pwdata", ncyc, bus.Pwdata,     0);
      chk("rst_rdata",  ncyc, bus.resp_rdata, 0);
      chk("rst_err",    ncyc, bus.resp_err,   0);
      @(posedge Pclk); #1 Prst = 1'b1;
      @(negedge Pclk);
      chk("post_rst_psel", ncyc, bus.Psel,      0);
      chk("post_rst_rr",   ncyc, bus.req_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
